// File: rtl/gb_oam_dma.sv
// OAM DMA engine: owns the 0xFF46 source register and copies DMA_LEN bytes from
// {src,8'h00} into OAM, one byte per M-cycle, while locking the CPU off the bus.
module gb_oam_dma #(
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] HRAM_LO      = 16'hFF80,
  parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_we_i,
  output logic [7:0]  cpu_data_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  output logic        mem_we_o,
  input  logic [7:0]  mem_data_i,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_data_o,
  output logic        oam_we_o,
  output logic        dma_active_o
);

  typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] idx, dma_reg, src;
  logic [7:0] oam_addr_q, oam_data_q;
  logic       reg_hit, reg_wr, hram_hit;
  logic [7:0] src_hi;

  assign reg_hit  = (cpu_addr_i == DMA_REG_ADDR);
  assign reg_wr   = cpu_we_i && reg_hit && (state != ACTIVE);
  assign hram_hit = (cpu_addr_i >= HRAM_LO) && (cpu_addr_i <= HRAM_HI);
  // Sources in 0xE0-0xFF fold onto the echo of work RAM.
  assign src_hi   = (src >= 8'hE0) ? (src & 8'hDF) : src;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 8'h00;
      dma_reg    <= 8'hFF;
      src        <= 8'h00;
      oam_addr_q <= 8'h00;
      oam_data_q <= 8'h00;
    end else begin
      state <= state_nxt;
      if (reg_wr) begin
        dma_reg <= cpu_data_i;
        src     <= cpu_data_i;
      end
      if (state == ACTIVE) begin
        idx        <= (idx == LAST_IDX) ? 8'h00 : idx + 8'h01;
        oam_addr_q <= idx;
        oam_data_q <= mem_data_i;
      end else begin
        idx <= 8'h00;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (reg_wr) state_nxt = START;
      START:   state_nxt = reg_wr ? START : ACTIVE;
      ACTIVE:  if (idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_o   = cpu_addr_i;
    mem_data_o   = cpu_data_i;
    mem_we_o     = cpu_we_i && !reg_wr;
    cpu_data_o   = reg_hit ? dma_reg : mem_data_i;
    oam_we_o     = 1'b0;
    oam_addr_o   = oam_addr_q;
    oam_data_o   = oam_data_q;
    dma_active_o = 1'b0;
    if (state == ACTIVE) begin
      mem_addr_o   = {src_hi, idx};
      mem_data_o   = 8'h00;
      mem_we_o     = 1'b0;
      // HRAM data is muxed in downstream; this block floats the bus high for all CPU reads.
      cpu_data_o   = hram_hit ? 8'hFF : 8'hFF;
      oam_we_o     = 1'b1;
      oam_addr_o   = idx;
      oam_data_o   = mem_data_i;
      dma_active_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: random CPU traffic checked every cycle against a
// cycle-number model of when the transfer window opens and closes.
module tb_gb_oam_dma;
  localparam int DMA_LEN = 160;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_we_i;
  logic [7:0]  cpu_data_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic        mem_we_o;
  logic [7:0]  mem_data_i;
  logic [7:0]  oam_addr_o;
  logic [7:0]  oam_data_o;
  logic        oam_we_o;
  logic        dma_active_o;

  gb_oam_dma dut (
    .clk(clk), .reset(reset),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_we_i(cpu_we_i),
    .cpu_data_o(cpu_data_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
    .mem_data_i(mem_data_i),
    .oam_addr_o(oam_addr_o), .oam_data_o(oam_data_o), .oam_we_o(oam_we_o),
    .dma_active_o(dma_active_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the transfer occupies cycles [start, start+DMA_LEN).
  int         n = 0;
  int         start = -1000;
  logic [7:0] m_reg = 8'hFF, m_src = 8'h00, m_oa = 8'h00, m_od = 8'h00;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic we, input logic rst);
    bit         act;
    int         i;
    logic [7:0] hi;
    @(negedge clk);
    reset = rst; cpu_addr_i = a; cpu_data_i = d; cpu_we_i = we;
    mem_data_i = 8'($urandom);
    #1;
    act = (n >= start) && (n < start + DMA_LEN);
    i   = n - start;
    hi  = (m_src >= 8'hE0) ? m_src - 8'h20 : m_src;
    chk("dma_active", 16'(dma_active_o), 16'(act));
    chk("oam_we", 16'(oam_we_o), 16'(act));
    chk("oam_addr", 16'(oam_addr_o), act ? 16'(i) : 16'(m_oa));
    chk("oam_data", 16'(oam_data_o), act ? 16'(mem_data_i) : 16'(m_od));
    chk("mem_we", 16'(mem_we_o), act ? 16'd0 : 16'(we && a != 16'hFF46));
    chk("mem_addr", mem_addr_o, act ? hi * 16'd256 + 16'(i) : a);
    chk("cpu_data", 16'(cpu_data_o),
        act ? 16'hFF : (a == 16'hFF46 ? 16'(m_reg) : 16'(mem_data_i)));
    if (!act) chk("mem_data", 16'(mem_data_o), 16'(d));
    @(posedge clk);
    if (rst) begin
      m_reg = 8'hFF; m_src = 8'h00; start = -1000; m_oa = 8'h00; m_od = 8'h00;
    end else if (act) begin
      m_oa = 8'(i); m_od = mem_data_i;
    end else if (we && a == 16'hFF46) begin
      m_reg = d; m_src = d; start = n + 2;
    end
    n++;
  endtask

  // Random CPU access; register writes only when allowed.
  task automatic rnd(input bit allow_reg);
    logic [15:0] tbl [7];
    logic [15:0] a;
    logic        we;
    tbl = '{16'hC000, 16'h8000, 16'hFF46, 16'hFF80, 16'hFFFE, 16'hFFFF, 16'($urandom)};
    a  = tbl[$urandom_range(6)];
    we = 1'($urandom);
    if (!allow_reg && a == 16'hFF46) we = 1'b0;
    cyc(a, 8'($urandom), we, 1'b0);
  endtask

  task automatic run(input int k, input bit allow_reg);
    for (int j = 0; j < k; j++) rnd(allow_reg);
  endtask

  initial begin
    reset = 1'b1; cpu_addr_i = 16'h0000; cpu_data_i = 8'h00; cpu_we_i = 1'b0; mem_data_i = 8'h00;
    cyc(16'h0000, 8'h00, 1'b0, 1'b1);
    cyc(16'h0000, 8'h00, 1'b0, 1'b1);
    cyc(16'hFF46, 8'h00, 1'b0, 1'b0);
    chk("reset_readback", 16'(cpu_data_o), 16'hFF);

    // Plain transfer, with CPU traffic (incl. ignored register writes) while active.
    cyc(16'hFF46, 8'hC1, 1'b1, 1'b0);
    run(1, 1'b0);
    cyc(16'hFF46, 8'h55, 1'b1, 1'b0);
    chk("first_addr_c1", mem_addr_o, 16'hC100);
    run(DMA_LEN + 3, 1'b1);

    // Echo-folded source.
    cyc(16'hFF46, 8'hFE, 1'b1, 1'b0);
    run(1, 1'b0);
    cyc(16'hC000, 8'h00, 1'b0, 1'b0);
    chk("first_addr_fe", mem_addr_o, 16'hDE00);
    run(DMA_LEN - 2, 1'b1);
    cyc(16'h8000, 8'h12, 1'b1, 1'b0);
    chk("last_addr_fe", mem_addr_o, 16'hDE9F);
    run(3, 1'b0);

    // Back-to-back register writes: the second one restarts the start delay.
    cyc(16'hFF46, 8'h80, 1'b1, 1'b0);
    cyc(16'hFF46, 8'h90, 1'b1, 1'b0);
    run(1, 1'b0);
    cyc(16'hFF80, 8'h00, 1'b0, 1'b0);
    chk("restart_addr", mem_addr_o, 16'h9000);
    run(DMA_LEN + 2, 1'b1);
    cyc(16'hFF46, 8'h00, 1'b0, 1'b0);
    chk("readback_90", 16'(cpu_data_o), 16'h90);

    // Reset while the transfer is at idx 50.
    cyc(16'hFF46, 8'h33, 1'b1, 1'b0);
    run(51, 1'b1);
    cyc(16'h0000, 8'h00, 1'b0, 1'b1);
    cyc(16'hFF46, 8'h00, 1'b0, 1'b0);
    chk("post_reset_active", 16'(dma_active_o), 16'h0);
    chk("post_reset_reg", 16'(cpu_data_o), 16'hFF);
    run(20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
